pipelined_prefix_adder: RTL and testbench
=========================================

# pipelined_prefix_adder

Parametrised, pipelined Kogge-Stone prefix adder/subtractor with a valid/ready stream interface, sideband tag and arithmetic flags. It generalises the fixed 16-bit single-register adder to any width and a configurable pipeline depth. It sits in the datapath as a drop-in arithmetic stage between stream producers and consumers that may apply backpressure.

## Interface
- BW, 16, operand/result width (>= 2)
- SPLIT, 1, prefix levels per pipeline segment (1..LEVELS), where LEVELS = clog2(BW+1) prefix levels over the BW+1 positions (carry-in at position -1)
- TW, 4, tag width (>= 1)
- CLK  input  1  clock, all state on rising edge
- RESETn  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous clear of all in-flight items
- in_valid  input  1  input item present
- in_ready  output  1  block accepts input this cycle
- a  input  BW  operand A
- b  input  BW  operand B
- cin  input  1  carry-in (op=0) / borrow-in (op=1)
- op  input  1  0 = a+b+cin, 1 = a-b-cin
- tag  input  TW  sideband, returned unchanged with result
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  BW  result
- cout  output  1  carry-out (op=0) / not-borrow (op=1)
- ovf  output  1  signed two's-complement overflow
- zero  output  1  sum == 0
- out_tag  output  TW  tag of the result

## Operation
- Operand conditioning: b_eff = op ? ~b : b; c_eff = op ? ~cin : cin. Result = a + b_eff + c_eff, modulo 2^BW.
- Preprocess: g[i] = a[i] & b_eff[i], p[i] = a[i] ^ b_eff[i]; position -1 has g = c_eff, p = 0.
- Prefix tree: Kogge-Stone, level k combines span 2^k (black cells where both G and P are needed, grey cells where only G is needed). LEVELS levels total.
- Carries: c[i] = G[i-1 : -1]; sum[i] = p[i] ^ c[i]; cout = c[BW]; ovf = c[BW-1] ^ c[BW]; zero = ~|sum.
- Pipeline: register rank after prefix level SPLIT, 2*SPLIT, ... (only ranks strictly before level LEVELS), plus one output rank holding sum/flags. Each rank carries a valid bit, tag, and all signals needed downstream (p vector, partial G/P).
- Stall: stall = out_valid & ~out_ready. When stall = 1 every rank holds; otherwise every rank advances. in_ready = ~stall & ~flush. Bubbles are not compressed.
- Input accepted when in_valid & in_ready; otherwise a bubble (valid 0) enters rank 1.
- flush: at the edge where flush = 1, every valid bit clears, data registers don't care; no input accepted that cycle; takes priority over stall.

## Timing
- Latency L = 1 + floor((LEVELS-1)/SPLIT) cycles from accept edge to out_valid, absent stalls. BW=16: LEVELS=5; SPLIT=1 -> L=5, SPLIT=2 -> L=3, SPLIT=5 -> L=1.
- Throughput one item per cycle when out_ready held 1.
- out_* stable while out_valid & ~out_ready (no data change, no valid drop).
- Reset (RESETn low, asynchronous): all valid bits 0, out_valid 0, sum 0, cout 0, ovf 0, zero 0, out_tag 0; in_ready = 1 from first cycle after release. Reset mid-stream discards all in-flight items.
- Order preserved; each accepted item produces exactly one result.

## Test plan
- Reset: assert RESETn low mid-stream with out_valid=1 -> outputs immediately 0, out_valid 0; after release in_ready=1, no stale results emerge.
- BW=16, SPLIT=1, op=0: a=0xFFFF, b=0x0001, cin=0, tag=3 -> after 5 cycles sum=0x0000, cout=1, ovf=0, zero=1, out_tag=3; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- op=1: a=0x8000, b=0x0001, cin=0 -> sum=0x7FFF, cout=1, ovf=1; a=0x0000, b=0x0001, cin=1 -> sum=0xFFFE, cout=0, ovf=0.
- Backpressure: 100 back-to-back items, out_ready random 50% -> results in order, tags sequential, none dropped/duplicated, outputs stable while stalled, in_ready=0 exactly when stalled.
- flush asserted with 3 items in flight -> no result for those items ever appears; next accepted item emerges after L cycles.
- Random regression vs behavioural model for BW in {8,16,33,64}, SPLIT in {1,2,LEVELS}: 10k items each, all flags match, measured latency equals L.

Source files
------------

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready stream interface,
// a sideband tag and carry/overflow/zero flags. Registers sit after every SPLIT prefix levels.
module pipelined_prefix_adder #(
  parameter int unsigned BW    = 16,
  parameter int unsigned SPLIT = 1,
  parameter int unsigned TW    = 4
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic          cin,
  input  logic          op,
  input  logic [TW-1:0] tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] sum,
  output logic          cout,
  output logic          ovf,
  output logic          zero,
  output logic [TW-1:0] out_tag
);

  // Prefix positions 0..BW map to bit positions -1..BW-1 (position 0 is the carry-in).
  localparam int N      = BW + 1;
  localparam int LEVELS = $clog2(N);
  localparam int SP     = SPLIT;
  localparam int NR     = (LEVELS - 1) / SP;
  localparam int NRA    = (NR > 0) ? NR : 1;

  // Group generate after applying prefix levels lo..hi; the group P is rebuilt internally.
  function automatic logic [N-1:0] ks_g(input logic [N-1:0] g_i, input logic [N-1:0] p_i,
                                        input int lo, input int hi);
    logic [N-1:0] g, p, gn, pn;
    int span;
    g = g_i;
    p = p_i;
    for (int k = 1; k <= LEVELS; k++) begin
      if (k >= lo && k <= hi) begin
        span = 1 << (k - 1);
        gn   = g;
        pn   = p;
        for (int j = 0; j < N; j++) begin
          if (j >= span) begin
            gn[j] = g[j] | (p[j] & g[j-span]);
            pn[j] = (j >= 2 * span) ? (p[j] & p[j-span]) : 1'b0;
          end
        end
        g = gn;
        p = pn;
      end
    end
    return g;
  endfunction

  // Group propagate after levels lo..hi; spans that reach the carry-in are grey cells (P = 0).
  function automatic logic [N-1:0] ks_p(input logic [N-1:0] p_i, input int lo, input int hi);
    logic [N-1:0] p, pn;
    int span;
    p = p_i;
    for (int k = 1; k <= LEVELS; k++) begin
      if (k >= lo && k <= hi) begin
        span = 1 << (k - 1);
        pn   = p;
        for (int j = 0; j < N; j++) begin
          if (j >= span) pn[j] = (j >= 2 * span) ? (p[j] & p[j-span]) : 1'b0;
        end
        p = pn;
      end
    end
    return p;
  endfunction

  logic          w_stall, w_acc;
  logic [BW-1:0] w_b_eff, w_pb0;
  logic          w_c_eff;
  logic [N-1:0]  w_g0, w_p0;

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall & ~flush;
  assign w_acc    = in_valid & in_ready;

  assign w_b_eff = op ? ~b : b;
  assign w_c_eff = op ? ~cin : cin;
  assign w_pb0   = a ^ w_b_eff;
  assign w_g0    = {a & w_b_eff, w_c_eff};
  assign w_p0    = {w_pb0, 1'b0};

  // Inputs to the last prefix segment, either straight from preprocessing or from the last rank.
  logic [N-1:0]  w_fg, w_fp;
  logic [BW-1:0] w_fpb;
  logic          w_fv;
  logic [TW-1:0] w_ftag;

  if (NR > 0) begin : g_ranks
    logic [N-1:0]  r_g   [NRA];
    logic [N-1:0]  r_p   [NRA];
    logic [BW-1:0] r_pb  [NRA];
    logic [TW-1:0] r_tag [NRA];
    logic [NRA-1:0] r_v;

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        r_v <= '0;
        for (int r = 0; r < NRA; r++) begin
          r_g[r]   <= '0;
          r_p[r]   <= '0;
          r_pb[r]  <= '0;
          r_tag[r] <= '0;
        end
      end else begin
        if (flush) begin
          r_v <= '0;
        end else if (!w_stall) begin
          r_v[0] <= w_acc;
          for (int r = 1; r < NR; r++) r_v[r] <= r_v[r-1];
        end
        if (!w_stall) begin
          r_g[0]   <= ks_g(w_g0, w_p0, 1, SP);
          r_p[0]   <= ks_p(w_p0, 1, SP);
          r_pb[0]  <= w_pb0;
          r_tag[0] <= tag;
          for (int r = 1; r < NR; r++) begin
            r_g[r]   <= ks_g(r_g[r-1], r_p[r-1], r * SP + 1, (r + 1) * SP);
            r_p[r]   <= ks_p(r_p[r-1], r * SP + 1, (r + 1) * SP);
            r_pb[r]  <= r_pb[r-1];
            r_tag[r] <= r_tag[r-1];
          end
        end
      end
    end

    assign w_fg   = r_g[NR-1];
    assign w_fp   = r_p[NR-1];
    assign w_fpb  = r_pb[NR-1];
    assign w_fv   = r_v[NR-1];
    assign w_ftag = r_tag[NR-1];
  end else begin : g_no_ranks
    assign w_fg   = w_g0;
    assign w_fp   = w_p0;
    assign w_fpb  = w_pb0;
    assign w_fv   = w_acc;
    assign w_ftag = tag;
  end

  // w_gf[i] is the carry into bit i; w_gf[BW] is the carry out.
  logic [N-1:0]  w_gf;
  logic [BW-1:0] w_sum;

  assign w_gf  = ks_g(w_fg, w_fp, NR * SP + 1, LEVELS);
  assign w_sum = w_fpb ^ w_gf[BW-1:0];

  logic          r_ov, r_cout, r_ovf, r_zero;
  logic [BW-1:0] r_sum;
  logic [TW-1:0] r_otag;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_ov   <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      r_otag <= '0;
    end else begin
      if (flush) begin
        r_ov <= 1'b0;
      end else if (!w_stall) begin
        r_ov <= w_fv;
      end
      if (!w_stall) begin
        r_sum  <= w_sum;
        r_cout <= w_gf[BW];
        r_ovf  <= w_gf[BW-1] ^ w_gf[BW];
        r_zero <= ~|w_sum;
        r_otag <= w_ftag;
      end
    end
  end

  assign out_valid = r_ov;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign out_tag   = r_otag;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench: BW=16/SPLIT=1 instance (L=5) and BW=64/SPLIT=3 instance (L=3),
// compared against an arithmetic reference model.
module tb_pipelined_prefix_adder;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  always #5 CLK = ~CLK;

  logic        sel;
  logic        t_flush, t_in_valid, t_out_ready, t_cin, t_op;
  logic [63:0] t_a, t_b;
  logic [3:0]  t_tag;

  logic        iv1, ir1, ov1, co1, of1, z1;
  logic [15:0] s1;
  logic [3:0]  tg1;
  logic        iv2, ir2, ov2, co2, of2, z2;
  logic [63:0] s2;
  logic [3:0]  tg2;

  assign iv1 = t_in_valid & ~sel;
  assign iv2 = t_in_valid & sel;

  pipelined_prefix_adder #(.BW(16), .SPLIT(1), .TW(4)) dut (
    .CLK(CLK), .RESETn(RESETn), .flush(t_flush), .in_valid(iv1), .in_ready(ir1),
    .a(t_a[15:0]), .b(t_b[15:0]), .cin(t_cin), .op(t_op), .tag(t_tag),
    .out_valid(ov1), .out_ready(t_out_ready), .sum(s1), .cout(co1), .ovf(of1), .zero(z1),
    .out_tag(tg1)
  );

  pipelined_prefix_adder #(.BW(64), .SPLIT(3), .TW(4)) dut2 (
    .CLK(CLK), .RESETn(RESETn), .flush(t_flush), .in_valid(iv2), .in_ready(ir2),
    .a(t_a), .b(t_b), .cin(t_cin), .op(t_op), .tag(t_tag),
    .out_valid(ov2), .out_ready(t_out_ready), .sum(s2), .cout(co2), .ovf(of2), .zero(z2),
    .out_tag(tg2)
  );

  logic        m_in_ready, m_out_valid;
  logic [70:0] m_res;
  assign m_in_ready  = sel ? ir2 : ir1;
  assign m_out_valid = sel ? ov2 : ov1;
  assign m_res = sel ? {s2, co2, of2, z2, tg2} : {48'd0, s1, co1, of1, z1, tg1};

  int errors = 0;
  int checks = 0;
  int bw;

  // Reference result {sum, cout, ovf, zero, tag} computed with wide integer arithmetic.
  function automatic logic [70:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic op, input logic [3:0] tg);
    logic [127:0] mask, aa, bb, full, s;
    logic c, v;
    mask = (128'd1 << w) - 128'd1;
    aa   = {64'd0, a} & mask;
    bb   = (op ? ~{64'd0, b} : {64'd0, b}) & mask;
    c    = op ? ~cin : cin;
    full = aa + bb + {127'd0, c};
    s    = full & mask;
    v    = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {s[63:0], full[w], v, (s == 128'd0), tg};
  endfunction

  task automatic send_one(input logic [63:0] a, input logic [63:0] b, input logic cin,
                          input logic op, input logic [3:0] tg, output int lat);
    t_a = a; t_b = b; t_cin = cin; t_op = op; t_tag = tg;
    t_out_ready = 1'b1;
    t_in_valid  = 1'b1;
    @(posedge CLK); #1;
    t_in_valid = 1'b0;
    lat = 1;
    while (!m_out_valid && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    bit seen;
    int n;
    #12;
    checks++;
    if ({m_out_valid, m_res} !== 72'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {m_out_valid, m_res});
    end
    @(negedge CLK) RESETn = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (m_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", m_in_ready);
    end
    // Fill the pipe with the consumer stalled, then reset mid-stream.
    t_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t_a = 64'(16'h1234 + i); t_b = 64'd7; t_tag = 4'(i + 1); t_in_valid = 1'b1;
      @(posedge CLK); #1;
    end
    t_in_valid = 1'b0;
    n = 0;
    while (!m_out_valid && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (m_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_prefill: out_valid got %b want 1", m_out_valid);
    end
    #3 RESETn = 1'b0;
    #1;
    checks++;
    if ({m_out_valid, m_res} !== 72'd0) begin
      errors++;
      $display("FAIL reset_async: got %h want 0", {m_out_valid, m_res});
    end
    #2 RESETn = 1'b1;
    t_out_ready = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (m_out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_stale: stale result got %b want 0", seen);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [4] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
    logic [15:0] vb [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
    logic        vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        vo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0]  vt [4] = '{4'd3, 4'd5, 4'd6, 4'd9};
    logic [15:0] es [4] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE};
    logic [2:0]  ef [4] = '{3'b101, 3'b010, 3'b110, 3'b000};
    int lat;
    for (int i = 0; i < 4; i++) begin
      send_one({48'd0, va[i]}, {48'd0, vb[i]}, vc[i], vo[i], vt[i], lat);
      checks++;
      if (lat !== 5) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d want 5", i, lat);
      end
      checks++;
      if (m_res !== {48'd0, es[i], ef[i], vt[i]}) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h want %h", i, m_res,
                 {48'd0, es[i], ef[i], vt[i]});
      end
    end
  endtask

  task automatic test_flush();
    bit seen;
    int lat;
    logic [70:0] exp;
    @(posedge CLK); #1;
    t_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t_a = 64'(i * 3 + 1); t_b = 64'd2; t_cin = 1'b0; t_op = 1'b0; t_tag = 4'(10 + i);
      t_in_valid = 1'b1;
      @(posedge CLK); #1;
    end
    t_flush = 1'b1;
    t_tag   = 4'hF;
    #1;
    checks++;
    if (m_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_ready: got %b want 0", m_in_ready);
    end
    @(posedge CLK); #1;
    t_flush = 1'b0;
    t_in_valid = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (m_out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_leak: result got %b want 0", seen);
    end
    t_a = {$urandom, $urandom}; t_b = {$urandom, $urandom};
    exp = model(bw, t_a, t_b, 1'b1, 1'b1, 4'h7);
    send_one(t_a, t_b, 1'b1, 1'b1, 4'h7, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL flush_next_latency: got %0d want 5", lat);
    end
    checks++;
    if (m_res !== exp) begin
      errors++;
      $display("FAIL flush_next_result: got %h want %h", m_res, exp);
    end
  endtask

  task automatic test_latency64();
    logic [63:0] la [3];
    logic [63:0] lb [3];
    logic        lo [3] = '{1'b0, 1'b0, 1'b1};
    logic [70:0] exp;
    int lat;
    la[0] = {$urandom, $urandom}; lb[0] = {$urandom, $urandom};
    la[1] = '1;                   lb[1] = 64'd1;
    la[2] = 64'h8000_0000_0000_0000; lb[2] = 64'd1;
    for (int i = 0; i < 3; i++) begin
      exp = model(64, la[i], lb[i], 1'b0, lo[i], 4'(i));
      send_one(la[i], lb[i], 1'b0, lo[i], 4'(i), lat);
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL w64_latency[%0d]: got %0d want 3", i, lat);
      end
      checks++;
      if (m_res !== exp) begin
        errors++;
        $display("FAIL w64_result[%0d]: got %h want %h", i, m_res, exp);
      end
    end
  endtask

  // Streams n items with random valid/ready; checks order, values, hold-while-stalled, in_ready.
  task automatic test_stream(input string name, input int n, input int vpct, input int rpct);
    logic [70:0] q[$];
    logic [70:0] exp, snap;
    bit prev_stall, acc;
    int issued, rcvd, cyc;
    prev_stall = 1'b0; acc = 1'b0; issued = 0; rcvd = 0; cyc = 0; snap = '0;
    t_in_valid = 1'b0;
    while (rcvd < n && cyc < 40 * n + 200) begin
      @(posedge CLK); #1;
      cyc++;
      if (prev_stall) begin
        checks++;
        if ({m_out_valid, m_res} !== {1'b1, snap}) begin
          errors++;
          $display("FAIL %s_hold: got %h want %h", name, {m_out_valid, m_res}, {1'b1, snap});
        end
      end
      if (acc) t_in_valid = 1'b0;
      t_out_ready = ($urandom_range(99) < rpct);
      if (!t_in_valid && issued < n && $urandom_range(99) < vpct) begin
        t_a = {$urandom, $urandom}; t_b = {$urandom, $urandom};
        t_cin = 1'($urandom_range(1)); t_op = 1'($urandom_range(1));
        t_tag = issued[3:0];
        t_in_valid = 1'b1;
        issued++;
      end
      #1;
      checks++;
      if (m_in_ready !== !(m_out_valid && !t_out_ready)) begin
        errors++;
        $display("FAIL %s_in_ready: got %b want %b", name, m_in_ready,
                 !(m_out_valid && !t_out_ready));
      end
      acc = t_in_valid && m_in_ready;
      if (acc) q.push_back(model(bw, t_a, t_b, t_cin, t_op, t_tag));
      if (m_out_valid && t_out_ready) begin
        rcvd++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL %s_extra: got %h want none", name, m_res);
        end else begin
          exp = q.pop_front();
          if (m_res !== exp) begin
            errors++;
            $display("FAIL %s_result: got %h want %h", name, m_res, exp);
          end
        end
      end
      prev_stall = m_out_valid && !t_out_ready;
      snap = m_res;
    end
    t_in_valid = 1'b0;
    checks++;
    if (rcvd != n || q.size() != 0) begin
      errors++;
      $display("FAIL %s_count: got %0d results (%0d pending) want %0d", name, rcvd, q.size(), n);
    end
  endtask

  initial begin
    sel = 1'b0; bw = 16;
    t_flush = 1'b0; t_in_valid = 1'b0; t_out_ready = 1'b1;
    t_cin = 1'b0; t_op = 1'b0; t_a = '0; t_b = '0; t_tag = '0;
    test_reset();
    test_directed();
    test_flush();
    test_stream("b2b", 100, 100, 50);
    test_stream("rand16", 400, 70, 70);
    @(posedge CLK); #1;
    sel = 1'b1; bw = 64;
    t_out_ready = 1'b1;
    test_latency64();
    test_stream("rand64", 1000, 80, 60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
